gpo_ctrl: RTL and testbench
===========================

# gpo_ctrl

Parametrised general-purpose output controller for the audio front end. It drives up to 8 output pins from a small register file on the 8-bit host register bus. Beyond a static level, each write can produce a timed one-shot pulse or a free-running blink pattern. It is the next-generation replacement for the single-register GPO with fixed 7 pins.

## Interface

Parameters:
- NUM_PINS, 7, number of driven pins, legal range 1..8
- CNT_W, 8, width of the period counter; the PERIOD register holds CNT_W bits, low byte written (CNT_W ≤ 8)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- addr  in  2  register address
- wr_en  in  1  write strobe, one cycle per write
- rd_en  in  1  read strobe
- data_in  in  8  write data
- data_out  out  8  registered read data
- gpo_pins  out  NUM_PINS  registered pin outputs
- busy  out  1  high while a pulse is in progress

## Operation

Registers (addr), reset value 0:
- 0 CTRL: [7] enable; [1:0] mode (00 static, 01 pulse, 10 blink, 11 reserved = static).
- 1 VALUE: [NUM_PINS-1:0] pin pattern; upper bits read 0.
- 2 PERIOD: [CNT_W-1:0] hold time. Each phase lasts PERIOD+1 cycles.
- 3 STATUS: read-only, [0] busy, [2:1] state code; writes are ignored.

State machine (states IDLE, STATIC, PULSE, BLINK_ON, BLINK_OFF):
- IDLE: pins 0.
  - Enters STATIC, PULSE or BLINK_ON when enable=1, according to mode.
  - From IDLE, pulse mode waits in IDLE until a VALUE write.
- STATIC: pins = VALUE, updated in the cycle after each VALUE write.
- PULSE: entered on a VALUE write with enable=1 and mode=pulse.
  - Counter loads PERIOD; pins = VALUE; busy=1.
  - Counter expiry at 0 → IDLE, pins 0, busy 0.
- BLINK_ON: pins = VALUE for PERIOD+1 cycles → BLINK_OFF.
- BLINK_OFF: pins = 0 for PERIOD+1 cycles → BLINK_ON.
- Any CTRL write goes to IDLE for the following cycle, then re-enters per the new mode. Counter reloads.
- enable=0 → IDLE from the next cycle, regardless of state.

Boundary rules:
- VALUE write during PULSE restarts the pulse with the new pattern and a reloaded counter.
- VALUE write during blink updates the pattern only. Phase and counter are unchanged.
- PERIOD write applies at the next counter load. A running phase is unaffected.
- PERIOD=0: each phase is 1 cycle, so blink toggles every cycle.
- Simultaneous wr_en and rd_en to the same address: data_out returns the old value.
- Reset mid-operation clears all registers, the counter and the outputs; state goes to IDLE.

## Timing

- Reset values: data_out=0, gpo_pins=0, busy=0, state IDLE.
- Register write: the value is visible in the register at clock edge N+1 after wr_en at edge N.
- Pins react one cycle after the register update, i.e. 2 cycles after wr_en.
- Read: rd_en at edge N → data_out valid after edge N+1.
  - data_out returns to 0 on any cycle with rd_en=0.
- Pulse width on the pins is exactly PERIOD+1 cycles.
- The blink period is 2·(PERIOD+1) cycles.
- gpo_pins and busy are driven from flops, with no combinational path from the inputs.

## Structure

- Package gpo_pkg holds:
  - mode_e enum (MODE_STATIC, MODE_PULSE, MODE_BLINK)
  - state_e enum (five states above)
  - address localparams ADDR_CTRL/VALUE/PERIOD/STATUS
  - CTRL bit positions
- Sub-module gpo_timer (CNT_W): down-counter with load, load_val, expired.
  - Instantiated once; the FSM and register file stay in gpo_ctrl.

## Test plan

- Reset: assert reset_n=0 mid-blink → gpo_pins=0, busy=0, data_out=0 immediately. Register reads return 0 after release.
- Static: write CTRL=0x80, VALUE=0x55 → gpo_pins=0x55 two cycles after the VALUE write. Read VALUE → data_out=0x55 for one cycle, then 0.
- Pulse: PERIOD=3, CTRL=0x81, VALUE=0x0F → pins=0x0F and busy=1 for exactly 4 cycles, then 0. Rewrite VALUE=0x70 in cycle 2 → a fresh 4-cycle pulse of 0x70.
- Blink: PERIOD=0, CTRL=0x82, VALUE=0x01 → pins alternate 0x01/0x00 every cycle. With PERIOD=2 the pattern is 3 cycles on, 3 cycles off.
- Disable/mode change: CTRL=0x02 during blink → pins 0 next cycle and held. STATUS reads IDLE. A write to addr 3 leaves state unchanged.
- Parameter sweep: NUM_PINS=1 and 8, CNT_W=4.
  - VALUE upper bits read back 0.
  - PERIOD=0xFF truncates to 0xF, giving a 16-cycle pulse.

Source files
------------

// File: rtl/gpo_pkg.sv
// Shared types and register map for the general-purpose output controller.
package gpo_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_PULSE  = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STATIC    = 3'd1,
        ST_PULSE     = 3'd2,
        ST_BLINK_ON  = 3'd3,
        ST_BLINK_OFF = 3'd4
    } state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_VALUE  = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN_BIT   = 7;
    localparam int CTRL_MODE_MSB = 1;
    localparam int CTRL_MODE_LSB = 0;

    // STATUS[2:1]: 0 idle, 1 static, 2 pulse, 3 blinking (either phase)
    function automatic logic [1:0] state_code(state_e s);
        case (s)
            ST_IDLE:   return 2'd0;
            ST_STATIC: return 2'd1;
            ST_PULSE:  return 2'd2;
            default:   return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/gpo_timer.sv
// Phase timer: loadable down-counter that parks at zero and flags expiry there.
module gpo_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/gpo_ctrl.sv
// GPO controller: host register file plus the static/pulse/blink sequencer
// driving up to 8 registered output pins.
//
// state        | meaning
// ST_IDLE      | pins 0; waits for enable (pulse mode also waits for a VALUE write)
// ST_STATIC    | pins follow VALUE
// ST_PULSE     | pins = VALUE, busy high, until the timer expires
// ST_BLINK_ON  | pins = VALUE for PERIOD+1 cycles
// ST_BLINK_OFF | pins 0 for PERIOD+1 cycles
module gpo_ctrl
    import gpo_pkg::*;
#(
    parameter int NUM_PINS = 7,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          addr,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [7:0]          data_in,
    output logic [7:0]          data_out,
    output logic [NUM_PINS-1:0] gpo_pins,
    output logic                busy
);

    logic                en_q;
    mode_e               mode_q;
    logic [NUM_PINS-1:0] value_q;
    logic [CNT_W-1:0]    period_q;
    logic                ctrl_wr_q;
    logic                value_wr_q;
    logic [7:0]          data_out_q;

    state_e              state_q, state_d;
    logic [NUM_PINS-1:0] pins_q, pins_d;
    logic                busy_q, busy_d;

    logic                tmr_load;
    logic                tmr_expired;
    logic [7:0]          rd_data;

    logic wr_ctrl, wr_value, wr_period;

    assign wr_ctrl   = wr_en && (addr == ADDR_CTRL);
    assign wr_value  = wr_en && (addr == ADDR_VALUE);
    assign wr_period = wr_en && (addr == ADDR_PERIOD);

    // Register file. The write strobes are also delayed one cycle so the FSM
    // reacts to a write at the same time it sees the updated register contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q       <= 1'b0;
            mode_q     <= MODE_STATIC;
            value_q    <= '0;
            period_q   <= '0;
            ctrl_wr_q  <= 1'b0;
            value_wr_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            ctrl_wr_q  <= wr_ctrl;
            value_wr_q <= wr_value;
            if (wr_ctrl) begin
                en_q   <= data_in[CTRL_EN_BIT];
                mode_q <= mode_e'(data_in[CTRL_MODE_MSB:CTRL_MODE_LSB]);
            end
            if (wr_value) begin
                value_q <= data_in[NUM_PINS-1:0];
            end
            if (wr_period) begin
                period_q <= data_in[CNT_W-1:0];
            end
            data_out_q <= rd_en ? rd_data : 8'h00;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_CTRL: begin
                rd_data[CTRL_EN_BIT]                 = en_q;
                rd_data[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
            end
            ADDR_VALUE:  rd_data[NUM_PINS-1:0] = value_q;
            ADDR_PERIOD: rd_data[CNT_W-1:0]    = period_q;
            default: begin
                rd_data[0]   = busy_q;
                rd_data[2:1] = state_code(state_q);
            end
        endcase
    end

    gpo_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (period_q),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        if (ctrl_wr_q || !en_q) begin
            state_d  = ST_IDLE;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    case (mode_q)
                        MODE_PULSE: begin
                            if (value_wr_q) begin
                                state_d  = ST_PULSE;
                                tmr_load = 1'b1;
                            end
                        end
                        MODE_BLINK: begin
                            state_d  = ST_BLINK_ON;
                            tmr_load = 1'b1;
                        end
                        default: state_d = ST_STATIC;
                    endcase
                end
                ST_STATIC: state_d = ST_STATIC;
                ST_PULSE: begin
                    if (value_wr_q) begin
                        tmr_load = 1'b1;
                    end else if (tmr_expired) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BLINK_ON: begin
                    if (tmr_expired) begin
                        state_d  = ST_BLINK_OFF;
                        tmr_load = 1'b1;
                    end
                end
                ST_BLINK_OFF: begin
                    if (tmr_expired) begin
                        state_d  = ST_BLINK_ON;
                        tmr_load = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Pins and busy are decoded from the next state so they change on the
    // same edge as the state register, straight out of flops.
    always_comb begin
        pins_d = '0;
        busy_d = 1'b0;
        case (state_d)
            ST_STATIC, ST_BLINK_ON: pins_d = value_q;
            ST_PULSE: begin
                pins_d = value_q;
                busy_d = 1'b1;
            end
            default: pins_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pins_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pins_q  <= pins_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out = data_out_q;
    assign gpo_pins = pins_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_gpo_ctrl.sv
// Bench for gpo_ctrl: three parameterisations share one host bus and are
// compared every cycle against a timeline-based reference model.
module tb_gpo_ctrl;

    localparam int NP [3] = '{7, 1, 8};
    localparam int CW [3] = '{8, 4, 4};

    localparam int A_OFF    = 0;
    localparam int A_STATIC = 1;
    localparam int A_PULSE  = 2;
    localparam int A_BLINK  = 3;

    typedef struct packed {
        logic [2:0][7:0] pins;
        logic [2:0]      busy;
        logic [2:0][7:0] dout;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;

    logic [6:0] pins0;
    logic [0:0] pins1;
    logic [7:0] pins2;
    logic [7:0] dout0, dout1, dout2;
    logic       busy0, busy1, busy2;

    logic [7:0] a_pins [3];
    logic [7:0] a_dout [3];
    logic       a_busy [3];

    int checks = 0;
    int errors = 0;

    exp_t sb_q[$];

    // reference model: register contents plus the current activity as a timeline
    int m_en [3], m_mode [3], m_val [3], m_per [3];
    int act [3], t_start [3], t_len [3], b_on [3];
    int pend_ctrl [3], pend_val [3], m_busy [3], m_code [3];
    int cyc;

    always #5 clk = ~clk;

    gpo_ctrl #(.NUM_PINS(7), .CNT_W(8)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(dout0), .gpo_pins(pins0), .busy(busy0)
    );
    gpo_ctrl #(.NUM_PINS(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(dout1), .gpo_pins(pins1), .busy(busy1)
    );
    gpo_ctrl #(.NUM_PINS(8), .CNT_W(4)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(dout2), .gpo_pins(pins2), .busy(busy2)
    );

    assign a_pins[0] = 8'(pins0);
    assign a_pins[1] = 8'(pins1);
    assign a_pins[2] = pins2;
    assign a_dout[0] = dout0;
    assign a_dout[1] = dout1;
    assign a_dout[2] = dout2;
    assign a_busy[0] = busy0;
    assign a_busy[1] = busy1;
    assign a_busy[2] = busy2;

    function automatic void chk(string name, int i, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %02h expected %02h", name, i, $time, got, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_en[i] = 0; m_mode[i] = 0; m_val[i] = 0; m_per[i] = 0;
            act[i] = A_OFF; t_start[i] = 0; t_len[i] = 1; b_on[i] = 0;
            pend_ctrl[i] = 0; pend_val[i] = 0; m_busy[i] = 0; m_code[i] = 0;
        end
        cyc = 0;
    endfunction

    // One clock edge: outputs after the edge follow from the registers and
    // write events of the previous edge; this edge's write lands afterwards.
    function automatic void model_edge(bit wr, bit rd, logic [1:0] a, logic [7:0] d);
        exp_t e;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            int vmask, pmask, rdv, pins;
            vmask = (1 << NP[i]) - 1;
            pmask = (1 << CW[i]) - 1;
            rdv = 0;
            if (rd) begin
                case (a)
                    2'd0: rdv = (m_en[i] << 7) | m_mode[i];
                    2'd1: rdv = m_val[i];
                    2'd2: rdv = m_per[i];
                    default: rdv = m_busy[i] | (m_code[i] << 1);
                endcase
            end
            if (pend_ctrl[i] != 0) begin
                act[i] = A_OFF;
            end else if (act[i] == A_OFF) begin
                if (m_en[i] != 0) begin
                    if (m_mode[i] == 2) begin
                        act[i] = A_BLINK; b_on[i] = 1; t_start[i] = cyc; t_len[i] = m_per[i] + 1;
                    end else if (m_mode[i] == 1) begin
                        if (pend_val[i] != 0) begin
                            act[i] = A_PULSE; t_start[i] = cyc; t_len[i] = m_per[i] + 1;
                        end
                    end else begin
                        act[i] = A_STATIC;
                    end
                end
            end else if (act[i] == A_PULSE) begin
                if (pend_val[i] != 0) begin
                    t_start[i] = cyc; t_len[i] = m_per[i] + 1;
                end else if (cyc - t_start[i] >= t_len[i]) begin
                    act[i] = A_OFF;
                end
            end else if (act[i] == A_BLINK) begin
                if (cyc - t_start[i] >= t_len[i]) begin
                    b_on[i] = 1 - b_on[i]; t_start[i] = cyc; t_len[i] = m_per[i] + 1;
                end
            end
            pins = (act[i] == A_STATIC || act[i] == A_PULSE || (act[i] == A_BLINK && b_on[i] != 0))
                   ? m_val[i] : 0;
            m_busy[i] = (act[i] == A_PULSE) ? 1 : 0;
            m_code[i] = act[i];
            e.pins[i] = 8'(pins);
            e.busy[i] = m_busy[i][0];
            e.dout[i] = 8'(rdv);
            pend_ctrl[i] = (wr && a == 2'd0) ? 1 : 0;
            pend_val[i]  = (wr && a == 2'd1) ? 1 : 0;
            if (wr) begin
                case (a)
                    2'd0: begin m_en[i] = int'(d[7]); m_mode[i] = int'(d[1:0]); end
                    2'd1: m_val[i] = int'(d) & vmask;
                    2'd2: m_per[i] = int'(d) & pmask;
                    default: ;
                endcase
            end
        end
        cyc++;
        sb_q.push_back(e);
    endfunction

    // monitor: the DUT presents pins/busy/data_out every cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    chk("pins", i, a_pins[i], e.pins[i]);
                    chk("busy", i, 8'(a_busy[i]), 8'(e.busy[i]));
                    chk("data_out", i, a_dout[i], e.dout[i]);
                end
            end
        end
    end

    task automatic step(bit wr, bit rd, logic [1:0] a, logic [7:0] d);
        wr_en = wr; rd_en = rd; addr = a; data_in = d;
        @(posedge clk);
        model_edge(wr, rd, a, d);
        #1;
    endtask

    task automatic wr_reg(logic [1:0] a, logic [7:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    task automatic rd_reg(logic [1:0] a);
        step(1'b0, 1'b1, a, 8'h00);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic do_reset();
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_pins", i, a_pins[i], 8'h00);
            chk("rst_busy", i, 8'(a_busy[i]), 8'h00);
            chk("rst_data_out", i, a_dout[i], 8'h00);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int r;
        logic [1:0] ra;
        reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; data_in = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        rd_reg(2'd1); rd_reg(2'd2); rd_reg(2'd3);

        // static
        wr_reg(2'd0, 8'h80); wr_reg(2'd1, 8'h55); idle(3);
        rd_reg(2'd1); idle(2);

        // pulse, then restart with a new pattern mid-pulse
        wr_reg(2'd2, 8'h03); wr_reg(2'd0, 8'h81); idle(2);
        wr_reg(2'd1, 8'h0F); idle(8);
        wr_reg(2'd1, 8'h0F); idle(1); wr_reg(2'd1, 8'h70); idle(8);

        // blink at PERIOD=0, then PERIOD=2 taking effect at the next phase load
        wr_reg(2'd2, 8'h00); wr_reg(2'd0, 8'h82); wr_reg(2'd1, 8'h01); idle(6);
        wr_reg(2'd2, 8'h02); idle(14);
        wr_reg(2'd1, 8'h7E); idle(5);

        // disable from blink, status read, STATUS write ignored
        wr_reg(2'd0, 8'h02); idle(3); rd_reg(2'd3);
        wr_reg(2'd3, 8'hFF); rd_reg(2'd3); idle(2);

        // simultaneous write and read of the same register returns the old value
        step(1'b1, 1'b1, 2'd1, 8'h33); rd_reg(2'd1);

        // reset in the middle of blinking
        wr_reg(2'd2, 8'h01); wr_reg(2'd0, 8'h82); wr_reg(2'd1, 8'h5A); idle(5);
        do_reset();
        rd_reg(2'd1); rd_reg(2'd2); rd_reg(2'd3);

        // PERIOD truncation on the narrow-counter instances, upper VALUE bits
        wr_reg(2'd2, 8'hFF); wr_reg(2'd0, 8'h81); wr_reg(2'd1, 8'hFF);
        rd_reg(2'd1); rd_reg(2'd2); idle(20); rd_reg(2'd3); idle(240);
        wr_reg(2'd0, 8'h83); wr_reg(2'd1, 8'hA5); idle(3);

        // randomized traffic
        wr_reg(2'd2, 8'h01);
        for (int k = 0; k < 2500; k++) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                wr_reg(2'd0, (($urandom_range(0, 9) == 0) ? 8'h00 : 8'h80) | 8'($urandom_range(0, 3))
                             | (8'($urandom) & 8'h7C));
            end else if (r < 14) begin
                wr_reg(2'd1, 8'($urandom));
            end else if (r < 18) begin
                wr_reg(2'd2, ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4)));
            end else if (r < 20) begin
                wr_reg(2'd3, 8'($urandom));
            end else if (r < 28) begin
                ra = 2'($urandom_range(1, 3));
                rd_reg(ra);
            end else if (r < 30) begin
                ra = 2'($urandom_range(1, 3));
                step(1'b1, 1'b1, ra, 8'($urandom));
            end else begin
                idle(1);
            end
        end

        idle(2);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
